// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// uart_rx_cfg : oversampled UART receiver with majority voting, parity/stop
//               options, break detection and valid/ready output.  Rev 1.0
// ============================================================================
module uart_rx_cfg #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_os,
   input  logic                 rx_pin,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] c_s0   = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] c_s1   = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] c_dec  = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP1     = 3'd4,
      S_STOP2     = 3'd5,
      S_WAIT_HIGH = 3'd6
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [1:0]             smp_q, smp_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   par_en_q, par_en_d;
   logic                   par_odd_q, par_odd_d;
   logic                   two_stop_q, two_stop_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   brk_q, brk_d;
   logic                   done_q, done_d;

   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   perr_out_q;
   logic                   ferr_out_q;
   logic                   brk_out_q;
   logic                   ovr_q;

   logic w_rs;
   logic w_maj;
   logic w_dec;
   logic w_last;
   logic w_par_exp;
   logic w_accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
      end
   end

   assign w_rs      = sync_q[SYNC_STAGES-1];
   // Third sample is the live synchronised level on the decision tick.
   assign w_maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & w_rs) | (smp_q[1] & w_rs);
   assign w_dec     = (cnt_q == c_dec);
   assign w_last    = (cnt_q == c_last);
   assign w_par_exp = (^shreg_q) ^ par_odd_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         smp_q      <= 2'b11;
         shreg_q    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         smp_q      <= smp_d;
         shreg_q    <= shreg_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         two_stop_q <= two_stop_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      smp_d      = smp_q;
      shreg_d    = shreg_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      two_stop_d = two_stop_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      done_d     = 1'b0;

      if (tick_os) begin
         if (state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
            cnt_d = w_last ? '0 : cnt_q + 1'b1;
         end
         if (cnt_q == c_s0) smp_d[0] = w_rs;
         if (cnt_q == c_s1) smp_d[1] = w_rs;

         case (state_q)
            S_IDLE: begin
               if (!w_rs) begin
                  state_d    = S_START;
                  cnt_d      = '0;
                  bit_d      = '0;
                  shreg_d    = '0;
                  par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  par_odd_d  = (parity_mode == 2'b10);
                  two_stop_d = two_stop;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
                  brk_d      = 1'b1;
               end
            end
            S_START: begin
               if (w_dec && w_maj) begin
                  state_d = S_IDLE;
               end else if (w_last) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
            end
            S_DATA: begin
               if (w_dec) begin
                  shreg_d = {w_maj, shreg_q[DATA_BITS-1:1]};
                  if (w_maj) brk_d = 1'b0;
               end
               if (w_last) begin
                  if (bit_q == c_bit_last) begin
                     state_d = par_en_q ? S_PARITY : S_STOP1;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (w_dec) begin
                  if (w_maj != w_par_exp) perr_d = 1'b1;
                  if (w_maj) brk_d = 1'b0;
               end
               if (w_last) state_d = S_STOP1;
            end
            S_STOP1: begin
               if (w_dec) begin
                  if (w_maj) brk_d  = 1'b0;
                  else       ferr_d = 1'b1;
                  if (!two_stop_q) begin
                     // Completing mid stop bit lets the next start edge be caught early.
                     done_d  = 1'b1;
                     state_d = w_maj ? S_IDLE : S_WAIT_HIGH;
                  end
               end else if (w_last && two_stop_q) begin
                  state_d = S_STOP2;
               end
            end
            S_STOP2: begin
               if (w_dec) begin
                  if (!w_maj) ferr_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = (ferr_q || !w_maj) ? S_WAIT_HIGH : S_IDLE;
               end
            end
            S_WAIT_HIGH: begin
               if (w_rs) state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign w_accept = valid_q & rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         brk_out_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else if (done_q && (!valid_q || w_accept)) begin
         data_q     <= shreg_q;
         valid_q    <= 1'b1;
         perr_out_q <= perr_q;
         ferr_out_q <= ferr_q;
         brk_out_q  <= brk_q;
         ovr_q      <= 1'b0;
      end else if (done_q) begin
         // Held word wins; the new frame is dropped and flagged.
         ovr_q <= 1'b1;
      end else if (w_accept) begin
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         brk_out_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = perr_out_q;
   assign frame_err   = ferr_out_q;
   assign break_det   = brk_out_q;
   assign overrun_err = ovr_q;
   assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_cfg : directed bench for uart_rx_cfg (8-bit and 7-bit instances).
// Rev 1.0
// ============================================================================
module tb_uart_rx_cfg;

   localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clks

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_os = 1'b0;
   logic [1:0] parity_mode = 2'b00;
   logic       two_stop = 1'b0;
   logic [1:0] r_tick_cnt = 2'd0;

   logic       rx8 = 1'b1, rdy8 = 1'b0;
   logic [7:0] d8;
   logic       v8, perr8, ferr8, brk8, ovr8, busy8;

   logic       rx7 = 1'b1, rdy7 = 1'b0;
   logic [6:0] d7;
   logic       v7, perr7, ferr7, brk7, ovr7, busy7;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      r_tick_cnt <= r_tick_cnt + 2'd1;
      tick_os    <= (r_tick_cnt == 2'd3);
   end

   uart_rx_cfg u_dut8 (
      .clk(clk), .reset(reset), .tick_os(tick_os), .rx_pin(rx8),
      .parity_mode(parity_mode), .two_stop(two_stop),
      .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
      .parity_err(perr8), .frame_err(ferr8), .break_det(brk8),
      .overrun_err(ovr8), .busy(busy8)
   );

   uart_rx_cfg #(.DATA_BITS(7)) u_dut7 (
      .clk(clk), .reset(reset), .tick_os(tick_os), .rx_pin(rx7),
      .parity_mode(parity_mode), .two_stop(two_stop),
      .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
      .parity_err(perr7), .frame_err(ferr7), .break_det(brk7),
      .overrun_err(ovr7), .busy(busy7)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic b);
      if (sel == 7) rx7 = b;
      else          rx8 = b;
   endtask

   task automatic drive_bit(input int sel, input logic b);
      set_line(sel, b);
      repeat (BIT_CLKS) @(posedge clk);
   endtask

   // par < 0: no parity bit; st2 < 0: no second stop bit.
   task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                             input int par, input logic st1, input int st2);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
      if (par >= 0) drive_bit(sel, par[0]);
      drive_bit(sel, st1);
      if (st2 >= 0) drive_bit(sel, st2[0]);
      set_line(sel, 1'b1);
   endtask

   task automatic accept(input int sel);
      @(negedge clk);
      if (sel == 7) rdy7 = 1'b1;
      else          rdy8 = 1'b1;
      @(negedge clk);
      rdy7 = 1'b0;
      rdy8 = 1'b0;
   endtask

   initial begin
      int  cyc;
      logic saw_busy;

      // Reset state
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(v8), 32'd0);
      chk("rst_busy",  32'(busy8), 32'd0);
      chk("rst_data",  32'(d8), 32'd0);
      chk("rst_ovr",   32'(ovr8), 32'd0);
      chk("rst_valid7", 32'(v7), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // 1: 0x4E even parity, latency and handshake
      parity_mode = 2'b01;
      cyc = 0;
      fork
         send_frame(8, 9'h04E, 8, 0, 1'b1, -1);
         begin
            while (!v8 && cyc < 900) begin
               @(negedge clk);
               cyc++;
            end
         end
      join
      chk("s1_valid_before_timeout", 32'(v8), 32'd1);
      chk("s1_latency_10p5_bits", 32'(cyc >= 10 * BIT_CLKS && cyc <= 11 * BIT_CLKS), 32'd1);
      chk("s1_data", 32'(d8), 32'h4E);
      chk("s1_perr", 32'(perr8), 32'd0);
      chk("s1_ferr", 32'(ferr8), 32'd0);
      chk("s1_brk",  32'(brk8), 32'd0);
      chk("s1_ovr",  32'(ovr8), 32'd0);
      accept(8);
      chk("s1_valid_cleared", 32'(v8), 32'd0);

      // 2: same frame, odd parity expected -> parity error
      parity_mode = 2'b10;
      send_frame(8, 9'h04E, 8, 0, 1'b1, -1);
      @(negedge clk);
      chk("s2_valid", 32'(v8), 32'd1);
      chk("s2_data",  32'(d8), 32'h4E);
      chk("s2_perr",  32'(perr8), 32'd1);
      chk("s2_ferr",  32'(ferr8), 32'd0);
      accept(8);
      chk("s2_perr_cleared", 32'(perr8), 32'd0);

      // 3: short low glitch is rejected
      parity_mode = 2'b00;
      saw_busy = 1'b0;
      rx8 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (busy8) saw_busy = 1'b1;
      end
      rx8 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy8) saw_busy = 1'b1;
      end
      chk("s3_busy_pulsed", 32'(saw_busy), 32'd1);
      chk("s3_busy_idle",   32'(busy8), 32'd0);
      chk("s3_no_valid",    32'(v8), 32'd0);

      // 4: back-to-back frames without accept -> overrun
      send_frame(8, 9'h0A5, 8, -1, 1'b1, -1);
      send_frame(8, 9'h03C, 8, -1, 1'b1, -1);
      @(negedge clk);
      chk("s4_valid", 32'(v8), 32'd1);
      chk("s4_data_first_kept", 32'(d8), 32'hA5);
      chk("s4_ovr", 32'(ovr8), 32'd1);
      accept(8);
      chk("s4_valid_cleared", 32'(v8), 32'd0);
      chk("s4_ovr_cleared", 32'(ovr8), 32'd0);
      repeat (200) @(negedge clk);
      chk("s4_no_second_word", 32'(v8), 32'd0);

      // 5: break then normal frame
      rx8 = 1'b0;
      repeat (11 * BIT_CLKS) @(posedge clk);
      @(negedge clk);
      chk("s5_brk_valid", 32'(v8), 32'd1);
      chk("s5_brk_data",  32'(d8), 32'h00);
      chk("s5_brk_det",   32'(brk8), 32'd1);
      chk("s5_brk_ferr",  32'(ferr8), 32'd1);
      chk("s5_wait_high_busy", 32'(busy8), 32'd1);
      accept(8);
      repeat (BIT_CLKS) @(posedge clk);
      rx8 = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("s5_no_restart_while_low", 32'(v8), 32'd0);
      chk("s5_idle_after_high", 32'(busy8), 32'd0);
      send_frame(8, 9'h055, 8, -1, 1'b1, -1);
      @(negedge clk);
      chk("s5_data55", 32'(d8), 32'h55);
      chk("s5_55_ferr", 32'(ferr8), 32'd0);
      chk("s5_55_brk",  32'(brk8), 32'd0);
      chk("s5_55_perr", 32'(perr8), 32'd0);
      accept(8);

      // 6: 7-bit instance, two stop bits, second stop low
      two_stop = 1'b1;
      send_frame(7, 9'h02A, 7, -1, 1'b1, 0);
      @(negedge clk);
      chk("s6_valid7", 32'(v7), 32'd1);
      chk("s6_data7",  32'(d7), 32'h2A);
      chk("s6_ferr7",  32'(ferr7), 32'd1);
      chk("s6_brk7",   32'(brk7), 32'd0);
      chk("s6_perr7",  32'(perr7), 32'd0);
      accept(7);
      chk("s6_valid7_cleared", 32'(v7), 32'd0);
      two_stop = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);

      // 7: asynchronous reset mid-frame clears held word
      send_frame(8, 9'h033, 8, -1, 1'b1, -1);
      @(negedge clk);
      chk("s7_held_data", 32'(d8), 32'h33);
      rx8 = 1'b0;
      repeat (5 * BIT_CLKS) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("s7_rst_valid", 32'(v8), 32'd0);
      chk("s7_rst_data",  32'(d8), 32'd0);
      chk("s7_rst_busy",  32'(busy8), 32'd0);
      rx8 = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("s7_post_busy",  32'(busy8), 32'd0);
      chk("s7_post_valid", 32'(v8), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
